// File: rtl/cpuc_grid_ctrl.sv
// Purpose: control end of the CPUC register grid; fetches and decodes micro-instructions
//          and drives one-hot tristate/register enables plus a conditional branch.
// Latency: 1 fetch cycle + ack wait + 1 execute cycle per instruction (min 2 cycles).
// Ports  : clk/rst (async active-low), start; imem_req/addr/ack/rdata fetch port;
//          cond_sel/cond_data branch condition; tristate_en/reg_we grid enables;
//          pc, busy, halted, err status.
module cpuc_grid_ctrl #(
   parameter int NUM_OF_REGS       = 4,
   parameter int NUM_OF_PC         = 1,
   parameter int NUM_OF_COMPONENTS = 8,
   parameter int DATA_WIDTH        = 32,
   parameter int IMEM_DEPTH        = 64,
   localparam int PC_W    = $clog2(IMEM_DEPTH),
   localparam int NCOL    = NUM_OF_REGS + NUM_OF_PC,
   localparam int SRC_W   = $clog2(NUM_OF_COMPONENTS),
   localparam int DST_W   = $clog2(NCOL),
   localparam int INSTR_W = 2 + SRC_W + DST_W + PC_W,
   localparam int TE_W    = NUM_OF_COMPONENTS * NCOL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  imem_req,
   output logic [PC_W-1:0]       imem_addr,
   input  logic                  imem_ack,
   input  logic [INSTR_W-1:0]    imem_rdata,
   output logic [SRC_W-1:0]      cond_sel,
   input  logic [DATA_WIDTH-1:0] cond_data,
   output logic [TE_W-1:0]       tristate_en,
   output logic [NCOL-1:0]       reg_we,
   output logic [PC_W-1:0]       pc,
   output logic                  busy,
   output logic                  halted,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_MOV  = 2'b01;
   localparam logic [1:0] OP_BNZ  = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   state_t             state;
   state_t             state_nxt;
   logic [INSTR_W-1:0] ir;

   // Instruction register fields, msb->lsb {op, src, dst, target}.
   logic [1:0]       ir_op;
   logic [SRC_W-1:0] ir_src;
   logic [DST_W-1:0] ir_dst;
   logic [PC_W-1:0]  ir_target;

   assign ir_op     = ir[INSTR_W-1 -: 2];
   assign ir_src    = ir[PC_W+DST_W +: SRC_W];
   assign ir_dst    = ir[PC_W +: DST_W];
   assign ir_target = ir[PC_W-1:0];

   // Field legality: field widths may encode more values than exist in the grid.
   logic src_ok;
   logic dst_ok;
   assign src_ok = 32'(ir_src) < NUM_OF_COMPONENTS;
   assign dst_ok = 32'(ir_dst) < NCOL;

   // Sequential pc increment wraps at IMEM_DEPTH even when it is not a power of two.
   logic [PC_W-1:0] pc_inc;
   assign pc_inc = (32'(pc) == IMEM_DEPTH - 1) ? '0 : pc + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   if (imem_ack) state_nxt = EXEC;
         EXEC:    state_nxt = (ir_op == OP_HALT) ? HALTED : FETCH;
         HALTED:  if (start) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers: pc, instruction register, sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc  <= '0;
         ir  <= '0;
         err <= 1'b0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (start) begin
                  pc  <= '0;
                  err <= 1'b0;
               end
            end
            FETCH: begin
               if (imem_ack) ir <= imem_rdata;
            end
            EXEC: begin
               case (ir_op)
                  OP_NOP: pc <= pc_inc;
                  OP_MOV: begin
                     pc <= pc_inc;
                     if (!(src_ok && dst_ok)) err <= 1'b1;
                  end
                  OP_BNZ: begin
                     // An illegal condition source never takes the branch.
                     pc <= (src_ok && (cond_data != '0)) ? ir_target : pc_inc;
                     if (!src_ok) err <= 1'b1;
                  end
                  default: ; // HALT keeps pc
               endcase
            end
            default: ;
         endcase
      end
   end

   // Outputs decode only from state and IR flops so the grid enables never see
   // a combinational path from imem or the condition input.
   always_comb begin
      imem_req    = 1'b0;
      imem_addr   = '0;
      busy        = 1'b0;
      halted      = 1'b0;
      tristate_en = '0;
      reg_we      = '0;
      cond_sel    = '0;
      case (state)
         FETCH: begin
            imem_req  = 1'b1;
            imem_addr = pc;
            busy      = 1'b1;
         end
         EXEC: begin
            busy = 1'b1;
            if (ir_op == OP_MOV && src_ok && dst_ok) begin
               tristate_en = TE_W'(1) << (32'(ir_src) * NCOL + 32'(ir_dst));
               reg_we      = NCOL'(1) << ir_dst;
            end
            if (ir_op == OP_BNZ) cond_sel = ir_src;
         end
         HALTED: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpuc_grid_ctrl.sv
// Bench for cpuc_grid_ctrl: an instruction-memory responder drives ack/rdata,
// pushes the expected execute-cycle enables to a scoreboard, and compares them
// when the execute cycle appears. A small pc/err/halted model tracks state.
module tb_cpuc_grid_ctrl;

   localparam int PC_W    = 6;
   localparam int NCOL    = 5;
   localparam int SRC_W   = 3;
   localparam int INSTR_W = 14;
   localparam int TE_W    = 40;

   logic               clk;
   logic               rst;
   logic               start;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic [SRC_W-1:0]   cond_sel;
   logic [31:0]        cond_data;
   logic [TE_W-1:0]    tristate_en;
   logic [NCOL-1:0]    reg_we;
   logic [PC_W-1:0]    pc;
   logic               busy;
   logic               halted;
   logic               err;

   cpuc_grid_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .cond_sel    (cond_sel),
      .cond_data   (cond_data),
      .tristate_en (tristate_en),
      .reg_we      (reg_we),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [TE_W-1:0]  te;
      logic [NCOL-1:0]  we;
      logic [SRC_W-1:0] cs;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [PC_W-1:0] pc_m;
   logic            err_m;
   logic            halted_m;

   function automatic logic [INSTR_W-1:0] mk(input logic [1:0] op, input int src,
                                              input int dst, input int tgt);
      return {op, 3'(src), 3'(dst), 6'(tgt)};
   endfunction

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pc_m     = '0;
      err_m    = 1'b0;
      halted_m = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!imem_req) begin
         errors++;
         $display("FAIL %s_req_timeout imem_req=%0b required=1", tag, imem_req);
      end
   endtask

   // Serve one fetch with 'delay' wait cycles, then check the execute cycle
   // against the scoreboard and the post-execute state against the model.
   task automatic exec_instr(input string tag, input logic [1:0] op, input int src,
                             input int dst, input int tgt, input int delay,
                             input logic [31:0] cond);
      exp_t e;
      exp_t got;
      logic [PC_W-1:0] inc;
      wait_req(tag);
      if (!imem_req) return;
      checks++;
      if (imem_addr !== pc_m) begin
         errors++;
         $display("FAIL %s_addr got=%0d required=%0d", tag, imem_addr, pc_m);
      end
      for (int i = 0; i < delay; i++) begin
         imem_rdata = 14'($urandom);
         @(negedge clk);
         checks++;
         if (imem_addr !== pc_m || imem_req !== 1'b1 || tristate_en !== '0 || reg_we !== '0) begin
            errors++;
            $display("FAIL %s_wait%0d addr=%0d req=%0b te=%h we=%b required addr=%0d req=1 te=0 we=0",
                     tag, i, imem_addr, imem_req, tristate_en, reg_we, pc_m);
         end
      end
      // Build expectation and drive the ack.
      e   = '0;
      inc = pc_m + 1'b1;
      case (op)
         2'b01: begin
            if (src < 8 && dst < NCOL) begin
               e.te[src*NCOL+dst] = 1'b1;
               e.we[dst]          = 1'b1;
            end else begin
               err_m = 1'b1;
            end
            pc_m = inc;
         end
         2'b10: begin
            e.cs = 3'(src);
            pc_m = (cond != 0) ? 6'(tgt) : inc;
         end
         2'b11: halted_m = 1'b1;
         default: pc_m = inc;
      endcase
      sb.push_back(e);
      imem_ack   = 1'b1;
      imem_rdata = mk(op, src, dst, tgt);
      cond_data  = cond;
      @(negedge clk);
      imem_ack = 1'b0;
      got = '{te: tristate_en, we: reg_we, cs: cond_sel};
      e   = sb.pop_front();
      checks++;
      if (got !== e || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_exec te=%h we=%b cs=%0d busy=%0b required te=%h we=%b cs=%0d busy=1",
                  tag, got.te, got.we, got.cs, busy, e.te, e.we, e.cs);
      end
      @(negedge clk);
      cond_data = '0;
      checks++;
      if (pc !== pc_m || err !== err_m || halted !== halted_m || tristate_en !== '0 || reg_we !== '0) begin
         errors++;
         $display("FAIL %s_post pc=%0d err=%0b halted=%0b te=%h we=%b required pc=%0d err=%0b halted=%0b te=0 we=0",
                  tag, pc, err, halted, tristate_en, reg_we, pc_m, err_m, halted_m);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks++;
      if (imem_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0 || pc !== '0 ||
          tristate_en !== '0 || reg_we !== '0 || cond_sel !== '0 || imem_addr !== '0) begin
         errors++;
         $display("FAIL reset_state req=%0b busy=%0b halted=%0b err=%0b pc=%0d te=%h we=%b required all 0",
                  imem_req, busy, halted, err, pc, tristate_en, reg_we);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start busy=%0b req=%0b required 0 0", busy, imem_req);
      end
   endtask

   task automatic test_mov_stream();
      do_start();
      exec_instr("mov_3_2", 2'b01, 3, 2, 0, 0, 32'h0);
      checks++;
      if (tristate_en !== '0 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL mov_next_req req=%0b te=%h required req=1 te=0", imem_req, tristate_en);
      end
      exec_instr("mov_pccol", 2'b01, 7, 4, 0, 0, 32'h0);
   endtask

   task automatic test_reset_mid_fetch();
      wait_req("rst_mid");
      imem_ack   = 1'b1;
      imem_rdata = mk(2'b01, 1, 1, 0);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== '0 || tristate_en !== '0 || reg_we !== '0) begin
         errors++;
         $display("FAIL rst_async req=%0b busy=%0b pc=%0d te=%h we=%b required all 0",
                  imem_req, busy, pc, tristate_en, reg_we);
      end
      @(negedge clk);
      imem_ack = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tristate_en !== '0 || reg_we !== '0 || pc !== '0) begin
         errors++;
         $display("FAIL rst_no_load busy=%0b te=%h we=%b pc=%0d required 0", busy, tristate_en, reg_we, pc);
      end
   endtask

   task automatic test_bnz();
      do_start();
      exec_instr("bnz_zero", 2'b10, 6, 0, 40, 0, 32'h0);
      exec_instr("bnz_take", 2'b10, 6, 0, 40, 0, 32'h1);
   endtask

   task automatic test_ack_delay();
      exec_instr("mov_delay3", 2'b01, 1, 0, 0, 3, 32'h0);
   endtask

   task automatic test_wrap_halt();
      exec_instr("bnz_63", 2'b10, 0, 0, 63, 0, 32'h8000_0000);
      exec_instr("nop_wrap", 2'b00, 0, 0, 0, 0, 32'h0);
      exec_instr("halt", 2'b11, 0, 0, 0, 0, 32'h0);
      // Acks while halted must not wake anything.
      imem_ack   = 1'b1;
      imem_rdata = mk(2'b01, 2, 2, 0);
      @(negedge clk);
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || tristate_en !== '0 || reg_we !== '0) begin
         errors++;
         $display("FAIL halt_hold halted=%0b busy=%0b te=%h required halted=1 busy=0 te=0",
                  halted, busy, tristate_en);
      end
      do_start();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== '0 || halted !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL restart req=%0b addr=%0d halted=%0b busy=%0b required 1 0 0 1",
                  imem_req, imem_addr, halted, busy);
      end
   endtask

   task automatic test_illegal();
      exec_instr("nop0", 2'b00, 0, 0, 0, 0, 32'h0);
      // start while busy is ignored: pc must not return to 0.
      wait_req("busy_start");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (imem_addr !== pc_m || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_start addr=%0d busy=%0b required addr=%0d busy=1", imem_addr, busy, pc_m);
      end
      exec_instr("mov_ill", 2'b01, 0, 7, 0, 0, 32'h0);
      exec_instr("nop_err", 2'b00, 0, 0, 0, 0, 32'h0);
      exec_instr("halt_err", 2'b11, 0, 0, 0, 0, 32'h0);
      do_start();
      checks++;
      if (err !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL err_clear err=%0b halted=%0b required 0 0", err, halted);
      end
   endtask

   initial begin
      start      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      cond_data  = '0;
      pc_m       = '0;
      err_m      = 1'b0;
      halted_m   = 1'b0;
      test_reset();
      test_mov_stream();
      test_reset_mid_fetch();
      test_bnz();
      test_ack_delay();
      test_wrap_halt();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
